// File: rtl/floor_display_ctrl.sv
// floor_display_ctrl
//   Registered, glitch-filtered floor indicator for the elevator car display.
//   A one-hot floor vector (up to 99 floors) drives two active-low seven-segment
//   digits (tens/ones), and the travel direction drives a third digit.
//   Extra behaviour: stability filtering of the floor vector, holding the last
//   floor between floors, a dash/dash fault display for multi-hot vectors, and
//   blinking of the floor digits while the door is open.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   floor      in   [NUM_FLOORS:1] floor sensor vector, bit k = at floor k
//   dir        in   2'b01 up, 2'b10 down, otherwise idle
//   door_open  in   door open indication
//   seg_tens   out  tens digit {g..a}, active-low
//   seg_ones   out  ones digit {g..a}, active-low
//   seg_dir    out  direction digit {g..a}, active-low
//   fault      out  high while a multi-hot vector is the accepted input
module floor_display_ctrl #(
  parameter int NUM_FLOORS = 8,
  parameter int GLITCH_CYC = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS:1]   floor,
  input  logic [1:0]            dir,
  input  logic                  door_open,
  output logic [6:0]            seg_tens,
  output logic [6:0]            seg_ones,
  output logic [6:0]            seg_dir,
  output logic                  fault
);

  if (NUM_FLOORS < 1 || NUM_FLOORS > 99) begin : g_bad_floors
    $error("floor_display_ctrl: NUM_FLOORS must be 1..99");
  end
  if (GLITCH_CYC < 1) begin : g_bad_glitch
    $error("floor_display_ctrl: GLITCH_CYC must be >= 1");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink
    $error("floor_display_ctrl: BLINK_DIV must be >= 2");
  end

  localparam int CNT_W = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(GLITCH_CYC - 1);
  localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_DIV - 1);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_UP    = 7'b1111110;
  localparam logic [6:0] GLYPH_DOWN  = 7'b1110111;

  typedef enum logic [1:0] {S_INIT, S_VALID, S_FAULT} state_e;

  function automatic logic [6:0] digit_glyph(input logic [6:0] d);
    case (d)
      7'd0:    digit_glyph = 7'b1000000;
      7'd1:    digit_glyph = 7'b1111001;
      7'd2:    digit_glyph = 7'b0100100;
      7'd3:    digit_glyph = 7'b0110000;
      7'd4:    digit_glyph = 7'b0011001;
      7'd5:    digit_glyph = 7'b0010010;
      7'd6:    digit_glyph = 7'b0000010;
      7'd7:    digit_glyph = 7'b1111000;
      7'd8:    digit_glyph = 7'b0000000;
      7'd9:    digit_glyph = 7'b0010000;
      default: digit_glyph = GLYPH_BLANK;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [NUM_FLOORS:1]   floor_prev_q;
  logic [CNT_W-1:0]      stab_q, stab_d;
  logic [6:0]            k_q, k_d;
  logic                  door_q;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  phase_on_q, phase_on_d;
  logic [6:0]            tens_d, ones_d, dir_d;
  logic                  fault_d;
  logic                  accept, is_zero, is_onehot;
  logic [6:0]            idx, k_tens, k_ones;

  // Input classification
  always_comb begin
    is_zero   = (floor == '0);
    is_onehot = $onehot(floor);
    idx       = '0;
    for (int i = 1; i <= NUM_FLOORS; i++) begin
      if (floor[i]) idx = 7'(i);
    end
  end

  // Stability filter: stab counts repeats of the same vector; acceptance fires
  // on the edge where GLITCH_CYC identical samples have been seen, and keeps
  // firing while the vector stays put (re-accepting is harmless).
  always_comb begin
    stab_d = '0;
    if (floor == floor_prev_q) begin
      stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
    end
    accept = (stab_d == STAB_MAX);
  end

  // Blink phase: the counter only runs while door_open is seen high on two
  // consecutive edges, so a rising edge clears it and forces the on phase.
  always_comb begin
    blink_cnt_d = '0;
    phase_on_d  = 1'b1;
    if (door_open && door_q) begin
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d = '0;
        phase_on_d  = ~phase_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_on_d  = phase_on_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      k_q          <= '0;
      floor_prev_q <= '0;
      stab_q       <= '0;
      door_q       <= 1'b0;
      blink_cnt_q  <= '0;
      phase_on_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      floor_prev_q <= floor;
      stab_q       <= stab_d;
      door_q       <= door_open;
      blink_cnt_q  <= blink_cnt_d;
      phase_on_q   <= phase_on_d;
    end
  end

  // Next-state logic; ZERO leaves k untouched so the last floor is held.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    if (accept) begin
      if (is_onehot) begin
        state_d = S_VALID;
        k_d     = idx;
      end else if (!is_zero && state_q == S_VALID) begin
        state_d = S_FAULT;
      end
    end
  end

  // Output logic. The floor digits follow the registered state (one edge after
  // acceptance) but use the next blink phase, so door changes show after a
  // single edge.
  always_comb begin
    k_tens  = k_q / 7'd10;
    k_ones  = k_q % 7'd10;
    tens_d  = GLYPH_BLANK;
    ones_d  = GLYPH_BLANK;
    fault_d = 1'b0;
    case (state_q)
      S_VALID: begin
        if (phase_on_d) begin
          tens_d = (k_q < 7'd10) ? GLYPH_BLANK : digit_glyph(k_tens);
          ones_d = digit_glyph(k_ones);
        end
      end
      S_FAULT: begin
        tens_d  = GLYPH_DASH;
        ones_d  = GLYPH_DASH;
        fault_d = 1'b1;
      end
      default: ;
    endcase
    case (dir)
      2'b01:   dir_d = GLYPH_UP;
      2'b10:   dir_d = GLYPH_DOWN;
      default: dir_d = GLYPH_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_tens <= GLYPH_BLANK;
      seg_ones <= GLYPH_BLANK;
      seg_dir  <= GLYPH_BLANK;
      fault    <= 1'b0;
    end else begin
      seg_tens <= tens_d;
      seg_ones <= ones_d;
      seg_dir  <= dir_d;
      fault    <= fault_d;
    end
  end

endmodule

// File: tb/tb_floor_display_ctrl.sv
module tb_floor_display_ctrl;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;
  localparam logic [6:0] UP = 7'b1111110;
  localparam logic [6:0] DN = 7'b1110111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:1] floor;
  logic [1:0]  dir;
  logic        door_open;
  logic [6:0]  seg_tens, seg_ones, seg_dir;
  logic        fault;
  logic [6:0]  g1_tens, g1_ones, g1_dir;
  logic        g1_fault;

  always #5 clk = ~clk;

  floor_display_ctrl #(.NUM_FLOORS(12), .GLITCH_CYC(4), .BLINK_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .floor(floor), .dir(dir), .door_open(door_open),
    .seg_tens(seg_tens), .seg_ones(seg_ones), .seg_dir(seg_dir), .fault(fault)
  );

  floor_display_ctrl #(.NUM_FLOORS(12), .GLITCH_CYC(1), .BLINK_DIV(2)) u_g1 (
    .clk(clk), .rst_n(rst_n), .floor(floor), .dir(dir), .door_open(door_open),
    .seg_tens(g1_tens), .seg_ones(g1_ones), .seg_dir(g1_dir), .fault(g1_fault)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [6:0] tens, ones, sdir;
    logic       flt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      nm;
    logic [12:1] fl;
    logic [1:0] d;
    int         ncyc;
    logic [6:0] tens, ones, sdir;
    logic       flt;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, expv);
    end
  endtask

  task automatic expect_now(input string nm, input logic [6:0] t, input logic [6:0] o,
                            input logic [6:0] d, input logic f);
    exp_t e;
    e.nm = nm; e.tens = t; e.ones = o; e.sdir = d; e.flt = f;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    chk({e.nm, ".tens"}, seg_tens, e.tens);
    chk({e.nm, ".ones"}, seg_ones, e.ones);
    chk({e.nm, ".dir"}, seg_dir, e.sdir);
    chk({e.nm, ".fault"}, {6'd0, fault}, {6'd0, e.flt});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{"init_multi",  12'h003, 2'b01, 5, BL, BL, UP, 1'b0};
    tbl[1]  = '{"f3_early",    12'h004, 2'b00, 4, BL, BL, BL, 1'b0};
    tbl[2]  = '{"f3_show",     12'h004, 2'b10, 1, BL, G3, DN, 1'b0};
    tbl[3]  = '{"pulse5",      12'h010, 2'b00, 2, BL, G3, BL, 1'b0};
    tbl[4]  = '{"zero_hold",   12'h000, 2'b11, 5, BL, G3, BL, 1'b0};
    tbl[5]  = '{"multi_fault", 12'h018, 2'b01, 5, DA, DA, UP, 1'b1};
    tbl[6]  = '{"fault_zero",  12'h000, 2'b00, 5, DA, DA, BL, 1'b1};
    tbl[7]  = '{"f8",          12'h080, 2'b10, 5, BL, G8, DN, 1'b0};
    tbl[8]  = '{"f12",         12'h800, 2'b01, 5, G1, G2, UP, 1'b0};
    tbl[9]  = '{"f10",         12'h200, 2'b00, 5, G1, G0, BL, 1'b0};
    tbl[10] = '{"f10_hold",    12'h000, 2'b00, 3, G1, G0, BL, 1'b0};
    tbl[11] = '{"f5",          12'h010, 2'b00, 5, BL, G5, BL, 1'b0};

    rst_n = 1'b0; floor = '0; dir = 2'b00; door_open = 1'b0;
    expect_now("reset", BL, BL, BL, 1'b0);
    tick(2);
    check_out();
    rst_n = 1'b1;

    // GLITCH_CYC=1 instance: accepted on first edge, displayed one edge later
    floor = 12'h040;
    tick(1);
    chk("g1_lat1.ones", g1_ones, BL);
    tick(1);
    chk("g1_lat2.ones", g1_ones, G7);
    chk("g1_lat2.tens", g1_tens, BL);
    chk("g1_lat2.dir", g1_dir, BL);
    chk("g1_lat2.fault", {6'd0, g1_fault}, 7'd0);

    for (int i = 0; i < 12; i++) begin
      floor = tbl[i].fl;
      dir   = tbl[i].d;
      expect_now(tbl[i].nm, tbl[i].tens, tbl[i].ones, tbl[i].sdir, tbl[i].flt);
      tick(tbl[i].ncyc);
      check_out();
    end

    // Door blink at floor 5: on 3, off 3, on 3, off, then fall restores
    door_open = 1'b1;
    for (int c = 0; c < 10; c++) begin
      expect_now($sformatf("blink%0d", c), BL, (((c / 3) % 2) == 0) ? G5 : BL, BL, 1'b0);
      tick(1);
      check_out();
    end
    door_open = 1'b0;
    expect_now("door_fall", BL, G5, BL, 1'b0);
    tick(1);
    check_out();

    // Floor accepted during the off phase appears when the phase returns on
    door_open = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 7) floor = 12'h100;
      expect_now($sformatf("blinkacc%0d", c), BL,
                 (((c / 3) % 2) == 0) ? ((c >= 12) ? G9 : G5) : BL, BL, 1'b0);
      tick(1);
      check_out();
    end

    // Fault while door open: dashes, no blinking
    floor = 12'h018;
    tick(5);
    for (int c = 0; c < 6; c++) begin
      expect_now($sformatf("fault_door%0d", c), DA, DA, BL, 1'b1);
      tick(1);
      check_out();
    end
    door_open = 1'b0;

    // Direction digit lags dir by one edge
    dir = 2'b01;
    #1;
    chk("dir_before_edge", seg_dir, BL);
    expect_now("dir_up", DA, DA, UP, 1'b1);   tick(1); check_out();
    dir = 2'b10;
    expect_now("dir_down", DA, DA, DN, 1'b1); tick(1); check_out();
    dir = 2'b11;
    expect_now("dir_11", DA, DA, BL, 1'b1);   tick(1); check_out();
    dir = 2'b00;
    expect_now("dir_00", DA, DA, BL, 1'b1);   tick(1); check_out();

    // Async reset mid-sequence, then filter restarts from scratch
    dir = 2'b01;
    tick(1);
    chk("pre_rst.dir", seg_dir, UP);
    #2 rst_n = 1'b0;
    #1;
    expect_now("async_rst", BL, BL, BL, 1'b0);
    check_out();
    #1 rst_n = 1'b1;
    floor = 12'h008;
    dir = 2'b00;
    expect_now("post_rst_wait", BL, BL, BL, 1'b0);
    tick(4);
    check_out();
    expect_now("post_rst_f4", BL, G4, BL, 1'b0);
    tick(1);
    check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
